// File: rtl/nn_pkg.sv
// Shared types for the MLP layer sequencer: data word, FSM state encoding and ReLU helper.
package nn_pkg;
    localparam int WORD_W = 32;

    typedef logic signed [WORD_W-1:0] word_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        RELEASE,
        OUT
    } seq_state_t;

    // Negative words clamp to zero; non-negative words pass through untouched.
    function automatic word_t relu_word(input word_t w);
        return w[WORD_W-1] ? '0 : w;
    endfunction
endpackage

// File: rtl/layer_sequencer_if.sv
// Bundle of the sequencer's input, output and product-unit handshakes.
// Valid/ready: a transfer occurs on a rising edge where valid && ready; the sender
// holds valid and data stable until that edge. mvp_start/mvp_done is level based.
interface layer_sequencer_if #(
    parameter int BIT_WIDTH = 32,
    parameter int DIM       = 5,
    parameter int SEL_W     = 2
);
    logic                           in_valid;
    logic                           in_ready;
    logic [DIM-1:0][BIT_WIDTH-1:0]  in_vec;
    logic                           out_valid;
    logic                           out_ready;
    logic [DIM-1:0][BIT_WIDTH-1:0]  out_vec;
    logic                           mvp_start;
    logic [DIM-1:0][BIT_WIDTH-1:0]  mvp_vec;
    logic [SEL_W-1:0]               layer_sel;
    logic                           mvp_done;
    logic [DIM-1:0][BIT_WIDTH-1:0]  mvp_result;

    modport slave (
        input  in_valid, in_vec, out_ready, mvp_done, mvp_result,
        output in_ready, out_valid, out_vec, mvp_start, mvp_vec, layer_sel
    );

    modport master (
        output in_valid, in_vec, out_ready, mvp_done, mvp_result,
        input  in_ready, out_valid, out_vec, mvp_start, mvp_vec, layer_sel
    );
endinterface

// File: rtl/relu_vec.sv
// DIM-wide combinational ReLU; when en is low the vector passes through unchanged.
module relu_vec
    import nn_pkg::*;
#(
    parameter int BIT_WIDTH = WORD_W,
    parameter int DIM       = 5
) (
    input  logic                          en,
    input  logic [DIM-1:0][BIT_WIDTH-1:0] vec,
    output logic [DIM-1:0][BIT_WIDTH-1:0] res
);
    for (genvar i = 0; i < DIM; i++) begin : g_lane
        if (BIT_WIDTH == WORD_W) begin : g_pkg
            assign res[i] = en ? relu_word(vec[i]) : vec[i];
        end else begin : g_generic
            assign res[i] = (en && vec[i][BIT_WIDTH-1]) ? '0 : vec[i];
        end
    end
endmodule

// File: rtl/layer_sequencer.sv
// Time-shares one DIM x DIM vector-matrix product unit across NUM_LAYERS dense layers,
// applying ReLU between layers and returning the last layer's vector.
module layer_sequencer
    import nn_pkg::*;
#(
    parameter int FRACTION_WIDTH = 15,
    parameter int BIT_WIDTH      = 32,
    parameter int DIM            = 5,
    parameter int NUM_LAYERS     = 3,
    parameter int RELU_LAST      = 0
) (
    input  logic               clk,
    input  logic               reset,
    layer_sequencer_if.slave   bus,
    output logic               busy,
    output logic [31:0]        cycle_count,
    output seq_state_t         state
);
    localparam int SEL_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_LAYERS - 1);

    if (FRACTION_WIDTH >= BIT_WIDTH) begin : g_bad_frac
        $error("FRACTION_WIDTH must be smaller than BIT_WIDTH");
    end

    logic                          in_ready_q;
    logic                          out_valid_q;
    logic                          mvp_start_q;
    logic [SEL_W-1:0]              sel_q;
    logic [DIM-1:0][BIT_WIDTH-1:0] act_reg;
    logic [DIM-1:0][BIT_WIDTH-1:0] relu_out;
    logic [31:0]                   run_cnt;
    logic [31:0]                   run_next;
    logic                          relu_en;

    // The final layer skips ReLU unless RELU_LAST asks for it.
    assign relu_en  = (sel_q != LAST_SEL) || (RELU_LAST != 0);
    assign run_next = (run_cnt == 32'hFFFF_FFFF) ? run_cnt : run_cnt + 32'd1;

    relu_vec #(
        .BIT_WIDTH (BIT_WIDTH),
        .DIM       (DIM)
    ) u_relu (
        .en  (relu_en),
        .vec (bus.mvp_result),
        .res (relu_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            mvp_start_q <= 1'b0;
            sel_q       <= '0;
            act_reg     <= '0;
            run_cnt     <= '0;
            cycle_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        act_reg     <= bus.in_vec;
                        sel_q       <= '0;
                        run_cnt     <= '0;
                        in_ready_q  <= 1'b0;
                        mvp_start_q <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    run_cnt <= run_next;
                    if (bus.mvp_done) begin
                        mvp_start_q <= 1'b0;
                        state       <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    run_cnt <= run_next;
                    act_reg <= relu_out;
                    state   <= RELEASE;
                end
                RELEASE: begin
                    run_cnt <= run_next;
                    // A done left high from this layer must clear before the next start.
                    if (!bus.mvp_done) begin
                        if (sel_q == LAST_SEL) begin
                            out_valid_q <= 1'b1;
                            cycle_count <= run_next;
                            state       <= OUT;
                        end else begin
                            sel_q       <= sel_q + 1'b1;
                            mvp_start_q <= 1'b1;
                            state       <= ISSUE;
                        end
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_vec   = act_reg;
    assign bus.mvp_start = mvp_start_q;
    assign bus.mvp_vec   = act_reg;
    assign bus.layer_sel = sel_q;
    assign busy          = (state != IDLE);
endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Controller that time-shares one vector-matrix product unit (vecMatProd, DIM x DIM) across NUM_LAYERS dense layers of a fixed-point MLP.
- Accepts an input activation vector over a valid/ready handshake and selects each layer's weight matrix through layer_sel.
- Drives the product unit's start/done handshake, applies ReLU between layers, feeds each result back as the next layer's input, and presents the final vector over a valid/ready handshake.
- Sits between the input buffer and the output/argmax stage of the inference pipeline.

Parameters:
FRACTION_WIDTH, 15, fractional bits of the Q-format word (pass-through to datapath; unused internally except documentation)
BIT_WIDTH, 32, width of each signed two's-complement data word
DIM, 5, vector length; product unit is DIM x DIM
NUM_LAYERS, 3, number of layers sequenced per inference (>=1)
RELU_LAST, 0, 1 = also apply ReLU after the final layer

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous active-high reset
in_valid  in  1  input vector valid
in_ready  out  1  block can accept input vector
in_vec  in  BIT_WIDTH x DIM  input activation vector
out_valid  out  1  final vector valid
out_ready  in  1  downstream accepts final vector
out_vec  out  BIT_WIDTH x DIM  final layer output vector
mvp_start  out  1  start to product unit
mvp_vec  out  BIT_WIDTH x DIM  vector operand to product unit
layer_sel  out  $clog2(NUM_LAYERS) (min 1)  weight-matrix select for current layer
mvp_done  in  1  product unit done (level)
mvp_result  in  BIT_WIDTH x DIM  product unit result
busy  out  1  high in any state other than IDLE
cycle_count  out  32  cycles spent in the last completed inference (IDLE exit to OUT entry)

Behaviour:
- Reset (synchronous, active-high) returns to IDLE from any state, including mid-operation. Reset values: in_ready=1, out_valid=0, mvp_start=0, layer_sel=0, busy=0, cycle_count=0, vector registers all 0. A product-unit computation in flight is abandoned; mvp_start drops on the next edge.
- States:
  - IDLE: in_ready=1. On in_valid, latch in_vec into act_reg, layer_sel<=0, run counter<=0, go to ISSUE.
  - ISSUE: mvp_start=1, mvp_vec=act_reg. When mvp_done=1, go to CAPTURE.
  - CAPTURE (1 cycle): act_reg<=f(mvp_result), with f=ReLU unless this is the last layer and RELU_LAST=0. mvp_start=0. Go to RELEASE.
  - RELEASE: mvp_start=0. Wait for mvp_done=0; this prevents a stale done from being taken for the next layer. Then:
    - if layer_sel==NUM_LAYERS-1: go to OUT, cycle_count<=run counter;
    - else: layer_sel++ and go to ISSUE.
  - OUT: out_valid=1, out_vec=act_reg, held stable until out_ready. On out_valid&&out_ready, go to IDLE; in_ready rises the following cycle.
- in_ready=0 in every state except IDLE; in_valid outside IDLE is ignored.
- ReLU: a word with MSB=1 becomes 0, otherwise unchanged. No saturation or rounding is performed here; width is preserved.
- Run counter: increments every cycle the FSM is not in IDLE or OUT, and saturates at 2^32-1.
- mvp_done already high on entry to ISSUE is accepted only after RELEASE has observed it low; this is guaranteed by construction.
- Minimum latency, in_valid accepted to out_valid: NUM_LAYERS x (1 ISSUE + product latency + 1 CAPTURE + 1 RELEASE) cycles.
- NUM_LAYERS=1: layer_sel is fixed at 0 and the ReLU choice is governed by RELU_LAST.

Decomposition:
- Package nn_pkg:
  - word_t (logic signed [BIT_WIDTH-1:0]);
  - seq_state_t enum {IDLE, ISSUE, CAPTURE, RELEASE, OUT};
  - function relu_word.
- Sub-module relu_vec: combinational, DIM-wide ReLU with an enable input, instantiated once on the mvp_result path.

Test Plan:
- Single inference, NUM_LAYERS=3, behavioural product model with 4-cycle latency and identity weights, in_vec={1.0,-2.0,3.0,0,-0.5} in Q15:
  - out_vec={1.0,0,3.0,0,0};
  - layer_sel steps 0,1,2;
  - cycle_count = 3x(1+4+1+1) = 21.
- RELU_LAST=0, one layer, weights = -identity, in_vec={2,-3,...}: out_vec={-2,3,...}, i.e. no ReLU on the final layer.
- Back-pressure: out_ready held low 10 cycles after out_valid. out_vec stable and out_valid high throughout, in_ready=0, in_valid pulses ignored. Handshake completes the cycle out_ready rises, then returns to IDLE.
- Slow done release: model holds mvp_done high 5 cycles after start drops. FSM stays in RELEASE, mvp_start=0, and the next layer's start asserts only after done falls.
- Reset asserted while in ISSUE on layer 1:
  - next edge: mvp_start=0, busy=0, in_ready=1, layer_sel=0, cycle_count=0;
  - a following inference produces correct output.
- Back-to-back inferences: in_valid held high continuously with out_ready=1. Each vector is accepted only in IDLE, both outputs are correct and in order, and cycle_count is reported identically for each.
